// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register index width, scoreboard entry layout and
// the deepest supported tracking window.
package pipe_pkg;

    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned DEPTH_MAX  = 4;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard signal bundle.
// Optional stall statistics appear when HAZARD_STALL_STATS_EN is defined.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int unsigned NUM_SRC    = 3
);

    logic                          id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
    logic [NUM_SRC-1:0]            id_src_used;
    logic [REG_ADDR_W-1:0]         id_dest;
    logic                          id_wb_en;
    logic                          id_is_load;
    logic                          forward_en;
    logic                          freeze;
    logic                          flush;
    logic                          hazard_detected;
    logic [2**REG_ADDR_W-1:0]      pending;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0]                   stall_cycles;
    logic [7:0]                    max_stall_run;
`endif

    modport master (
`ifdef HAZARD_STALL_STATS_EN
        input  stall_cycles,
        input  max_stall_run,
`endif
        output id_valid,
        output id_src,
        output id_src_used,
        output id_dest,
        output id_wb_en,
        output id_is_load,
        output forward_en,
        output freeze,
        output flush,
        input  hazard_detected,
        input  pending
    );

    modport slave (
`ifdef HAZARD_STALL_STATS_EN
        output stall_cycles,
        output max_stall_run,
`endif
        input  id_valid,
        input  id_src,
        input  id_src_used,
        input  id_dest,
        input  id_wb_en,
        input  id_is_load,
        input  forward_en,
        input  freeze,
        input  flush,
        output hazard_detected,
        output pending
    );

endinterface

// File: rtl/hazard_scoreboard_src_match_unit.sv
// Compares one ID source slot against every tracked in-flight write-back.
module src_match_unit
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  id_valid,
    input  logic                  src_used,
    input  logic [REG_ADDR_W-1:0] src,
    input  sb_entry_t [DEPTH-1:0] entries,
    output logic                  any_match,
    output logic                  load_exe_match
);

    logic reading;

    assign reading = id_valid & src_used;

    always_comb begin
        any_match = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (reading && entries[i].valid && (entries[i].dest == src)) begin
                any_match = 1'b1;
            end
        end
    end

    // Only a load still in EXE cannot be forwarded in time.
    assign load_exe_match = reading & entries[0].valid & entries[0].is_load &
                            (entries[0].dest == src);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-side hazard scoreboard: tracks DEPTH in-flight write-backs and raises the ID/IF stall.
// Optional stall statistics are enabled with HAZARD_STALL_STATS_EN.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned DEPTH      = 2
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave sb
);

    sb_entry_t [DEPTH-1:0] entry_q, entry_d;
    logic [NUM_SRC-1:0]    any_match;
    logic [NUM_SRC-1:0]    load_match;
    logic                  hazard;
    logic [2**REG_ADDR_W-1:0] pending;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        src_match_unit #(.DEPTH(DEPTH)) u_match (
            .id_valid       (sb.id_valid),
            .src_used       (sb.id_src_used[k]),
            .src            (sb.id_src[k*REG_ADDR_W +: REG_ADDR_W]),
            .entries        (entry_q),
            .any_match      (any_match[k]),
            .load_exe_match (load_match[k])
        );
    end

    always_comb begin
        hazard = 1'b0;
        if (rst && !sb.flush && sb.id_valid) begin
            hazard = sb.forward_en ? (|load_match) : (|any_match);
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_q[i].valid) begin
                pending[entry_q[i].dest] = 1'b1;
            end
        end
    end

    assign sb.hazard_detected = hazard;
    assign sb.pending         = pending;

    always_comb begin
        entry_d = entry_q;
        if (sb.flush) begin
            entry_d = '0;
        end else if (!sb.freeze) begin
            for (int unsigned i = DEPTH - 1; i > 0; i--) begin
                entry_d[i] = entry_q[i-1];
            end
            // A stalled or empty ID slot becomes a bubble; non-writers also enter invalid.
            if (hazard || !sb.id_valid || !sb.id_wb_en) begin
                entry_d[0] = '0;
            end else begin
                entry_d[0].valid   = 1'b1;
                entry_d[0].dest    = sb.id_dest;
                entry_d[0].is_load = sb.id_is_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [7:0]  run_q, run_d;
    logic [7:0]  max_run_q, max_run_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        run_d          = run_q;
        max_run_d      = max_run_q;
        if (!sb.freeze) begin
            if (hazard) begin
                stall_cycles_d = stall_cycles_q + 32'd1;
                run_d          = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
            end else begin
                run_d = '0;
            end
            if (run_d > max_run_q) begin
                max_run_d = run_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            run_q          <= '0;
            max_run_q      <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            run_q          <= run_d;
            max_run_q      <= max_run_d;
        end
    end

    assign sb.stall_cycles  = stall_cycles_q;
    assign sb.max_stall_run = max_run_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard (DEPTH=2); stats checks when HAZARD_STALL_STATS_EN is defined.
module tb_hazard_scoreboard;

    localparam int unsigned RW = 4;
    localparam int unsigned NS = 3;
    localparam int unsigned DP = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(RW), .NUM_SRC(NS)) sb_if ();

    hazard_scoreboard #(.REG_ADDR_W(RW), .NUM_SRC(NS), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    typedef struct packed {
        logic        haz;
        logic [15:0] pend;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] b(input int unsigned r);
        return 16'(1) << r;
    endfunction

    task automatic set_id(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                          input logic [3:0] s2, input logic [2:0] used,
                          input logic [3:0] dest, input logic wb, input logic ld);
        sb_if.id_valid    = v;
        sb_if.id_src      = {s2, s1, s0};
        sb_if.id_src_used = used;
        sb_if.id_dest     = dest;
        sb_if.id_wb_en    = wb;
        sb_if.id_is_load  = ld;
    endtask

    // Invalid ID slot whose sources would otherwise match pending registers.
    task automatic nop();
        set_id(1'b0, 4'd1, 4'd2, 4'd5, 3'b111, 4'd1, 1'b1, 1'b0);
    endtask

    task automatic step(input string tag, input logic haz, input logic [15:0] pend);
        exp_t e;
        string t;
        exp_q.push_back('{haz: haz, pend: pend});
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".haz"}, {31'd0, sb_if.hazard_detected}, {31'd0, e.haz});
        chk({t, ".pend"}, {16'd0, sb_if.pending}, {16'd0, e.pend});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b0;
        sb_if.forward_en = 1'b0;
        sb_if.freeze     = 1'b0;
        sb_if.flush      = 1'b0;
        set_id(1'b1, 4'd1, 4'd3, 4'd0, 3'b011, 4'd2, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        step("rst_a", 1'b0, 16'h0);
        step("rst_b", 1'b0, 16'h0);
`ifdef HAZARD_STALL_STATS_EN
        chk("rst_stall_cycles", sb_if.stall_cycles, 32'd0);
        chk("rst_max_run", {24'd0, sb_if.max_stall_run}, 32'd0);
`endif
        rst = 1'b1;

        // ADD R1 ; SUB R2,R1,R3 without forwarding
        set_id(1'b1, 4'd2, 4'd3, 4'd0, 3'b011, 4'd1, 1'b1, 1'b0);
        step("add_r1", 1'b0, 16'h0);
        set_id(1'b1, 4'd1, 4'd3, 4'd0, 3'b011, 4'd2, 1'b1, 1'b0);
        step("dep1", 1'b1, b(1));
        step("dep2", 1'b1, b(1));
        step("dep_go", 1'b0, 16'h0);
        nop();
        step("drn1", 1'b0, b(2));
        step("drn2", 1'b0, b(2));
        step("drn3", 1'b0, 16'h0);

        // Forwarding: load-use stalls once, ALU producer does not stall
        sb_if.forward_en = 1'b1;
        set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1, 1'b1);
        step("ldr_r4", 1'b0, 16'h0);
        set_id(1'b1, 4'd4, 4'd6, 4'd0, 3'b011, 4'd5, 1'b1, 1'b0);
        step("ldu1", 1'b1, b(4));
        step("ldu_go", 1'b0, b(4));
        nop();
        step("f_d1", 1'b0, b(5));
        step("f_d2", 1'b0, b(5));
        step("f_d3", 1'b0, 16'h0);
        set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1, 1'b0);
        step("add_r4", 1'b0, 16'h0);
        set_id(1'b1, 4'd4, 4'd6, 4'd0, 3'b011, 4'd5, 1'b1, 1'b0);
        step("fwd_alu", 1'b0, b(4));
        nop();
        step("a_d1", 1'b0, b(4) | b(5));
        step("a_d2", 1'b0, b(5));
        step("a_d3", 1'b0, 16'h0);
        sb_if.forward_en = 1'b0;

        // Per-slot source-used gating
        set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1, 1'b0);
        step("su_add", 1'b0, 16'h0);
        set_id(1'b1, 4'd7, 4'd1, 4'd8, 3'b001, 4'd2, 1'b0, 1'b0);
        step("su_001", 1'b0, b(1));
        set_id(1'b1, 4'd7, 4'd1, 4'd8, 3'b010, 4'd2, 1'b0, 1'b0);
        step("su_010", 1'b1, b(1));
        nop();
        step("su_d", 1'b0, 16'h0);

        // Freeze during a stall
        set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1, 1'b0);
        step("fz_add", 1'b0, 16'h0);
        set_id(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd2, 1'b1, 1'b0);
        step("fz_dep", 1'b1, b(1));
        sb_if.freeze = 1'b1;
        for (int i = 0; i < 3; i++) step("fz_hold", 1'b1, b(1));
        sb_if.freeze = 1'b0;
        step("fz_rest", 1'b1, b(1));
        step("fz_go", 1'b0, 16'h0);
        nop();
        step("fz_d1", 1'b0, b(2));
        step("fz_d2", 1'b0, b(2));
        step("fz_d3", 1'b0, 16'h0);

        // Flush (with freeze also high) kills everything in flight
        set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1, 1'b0);
        step("fl_a1", 1'b0, 16'h0);
        set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd2, 1'b1, 1'b0);
        step("fl_a2", 1'b0, b(1));
        set_id(1'b1, 4'd1, 4'd2, 4'd0, 3'b011, 4'd3, 1'b0, 1'b0);
        sb_if.flush  = 1'b1;
        sb_if.freeze = 1'b1;
        step("fl_on", 1'b0, b(1) | b(2));
        sb_if.flush  = 1'b0;
        sb_if.freeze = 1'b0;
        step("fl_after", 1'b0, 16'h0);
        nop();
        step("fl_d", 1'b0, 16'h0);

        // Reset in the middle of a stall
        set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1, 1'b0);
        step("rs_add", 1'b0, 16'h0);
        set_id(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd2, 1'b0, 1'b0);
        step("rs_stall", 1'b1, b(1));
        rst = 1'b0;
        step("rs_low", 1'b0, b(1));
        rst = 1'b1;
        step("rs_after", 1'b0, 16'h0);

`ifdef HAZARD_STALL_STATS_EN
        chk("st_cleared", sb_if.stall_cycles, 32'd0);
        for (int p = 0; p < 3; p++) begin
            set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1, 1'b0);
            step("st_add", 1'b0, 16'h0);
            set_id(1'b1, 4'd1, 4'd3, 4'd0, 3'b011, 4'd2, 1'b0, 1'b0);
            step("st_dep1", 1'b1, b(1));
            step("st_dep2", 1'b1, b(1));
            step("st_go", 1'b0, 16'h0);
        end
        chk("stall_cycles", sb_if.stall_cycles, 32'd6);
        chk("max_stall_run", {24'd0, sb_if.max_stall_run}, 32'd2);
`endif

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
